// File: rtl/turn_scheduler.sv
// turn_scheduler: turn order, per-step countdown and round counting for Generals.
// Player 0 is the NPC and never takes a turn; humans are numbered 1..MAX_PLAYER_CNT.
module turn_scheduler #(
  parameter int MAX_PLAYER_CNT      = 7,
  parameter int LOG2_MAX_PLAYER_CNT = $clog2(MAX_PLAYER_CNT + 1),
  parameter int MAX_STEP_TIME       = 15,
  parameter int LOG2_MAX_STEP_TIME  = $clog2(MAX_STEP_TIME + 1),
  parameter int LOG2_MAX_ROUND      = 12,
  parameter int TICKS_PER_SEC       = 50_000_000
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [LOG2_MAX_PLAYER_CNT-1:0] first_player,
  input  logic [MAX_PLAYER_CNT-1:0]      alive_mask,
  input  logic                           move_done,
  output logic [1:0]                     state,
  output logic [LOG2_MAX_PLAYER_CNT-1:0] current_player,
  output logic [LOG2_MAX_PLAYER_CNT-1:0] next_player,
  output logic [LOG2_MAX_STEP_TIME-1:0]  step_timer,
  output logic [LOG2_MAX_ROUND-1:0]      round,
  output logic                           turn_start,
  output logic                           game_over,
  output logic [LOG2_MAX_PLAYER_CNT-1:0] winner
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [LOG2_MAX_PLAYER_CNT-1:0] cur_q, cur_d;
  logic [LOG2_MAX_STEP_TIME-1:0]  timer_q, timer_d;
  logic [LOG2_MAX_ROUND-1:0]      round_q, round_d;
  logic                           ts_q, ts_d;
  logic [LOG2_MAX_PLAYER_CNT-1:0] win_q, win_d;
  logic [PW-1:0]                  pres_q, pres_d;
  logic                           start_q;

  // First alive player strictly after base, cyclically; base itself is the
  // last candidate. base=0 scans from player 1. Returns 0 if nobody is alive.
  function automatic logic [LOG2_MAX_PLAYER_CNT-1:0] scan_after(
    input logic [LOG2_MAX_PLAYER_CNT-1:0] base,
    input logic [MAX_PLAYER_CNT-1:0]      mask
  );
    logic [LOG2_MAX_PLAYER_CNT-1:0] res;
    int best, d, b;
    res  = '0;
    best = MAX_PLAYER_CNT + 1;
    b    = (int'(base) > MAX_PLAYER_CNT) ? 0 : int'(base);
    for (int i = 0; i < MAX_PLAYER_CNT; i++) begin
      d = (i + 1) - b;
      if (d <= 0) d = d + MAX_PLAYER_CNT;
      if (mask[i] && d < best) begin
        best = d;
        res  = LOG2_MAX_PLAYER_CNT'(i + 1);
      end
    end
    return res;
  endfunction

  logic                           start_rise;
  logic                           cur_alive, fp_alive, fp_in_range;
  logic [LOG2_MAX_PLAYER_CNT-1:0] first_sel;
  logic [LOG2_MAX_PLAYER_CNT-1:0] lone_idx;
  logic                           few_alive;
  logic                           sec_tick;

  // Status decode of the alive set, current player and requested first player.
  always_comb begin
    cur_alive   = 1'b0;
    fp_alive    = 1'b0;
    lone_idx    = '0;
    fp_in_range = (int'(first_player) >= 1) && (int'(first_player) <= MAX_PLAYER_CNT);
    for (int i = 0; i < MAX_PLAYER_CNT; i++) begin
      if (int'(cur_q) == i + 1)        cur_alive = alive_mask[i];
      if (int'(first_player) == i + 1) fp_alive  = alive_mask[i];
      if (alive_mask[i])               lone_idx  = LOG2_MAX_PLAYER_CNT'(i + 1);
    end
    few_alive   = ($countones(alive_mask) <= 1);
    if (!few_alive || $countones(alive_mask) == 0) lone_idx = '0;
    next_player = scan_after(cur_q, alive_mask);
    first_sel   = fp_alive ? first_player
                           : scan_after(fp_in_range ? first_player : '0, alive_mask);
    start_rise  = start & ~start_q;
    sec_tick    = (pres_q == PW'(TICKS_PER_SEC - 1));
  end

  // Next-state and datapath update: start handling, priority checks, advance.
  always_comb begin
    logic adv;
    state_d = state_q;
    cur_d   = cur_q;
    timer_d = timer_q;
    round_d = round_q;
    ts_d    = 1'b0;
    win_d   = win_q;
    pres_d  = pres_q;
    adv     = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (start_rise) begin
          if (few_alive) begin
            state_d = OVER;
            win_d   = lone_idx;
          end else begin
            state_d = RUN;
            cur_d   = first_sel;
            round_d = LOG2_MAX_ROUND'(1);
            timer_d = LOG2_MAX_STEP_TIME'(MAX_STEP_TIME);
            ts_d    = 1'b1;
            pres_d  = '0;
            win_d   = '0;
          end
        end
      end
      RUN: begin
        if (few_alive) begin
          state_d = OVER;
          win_d   = lone_idx;
        end else if (!cur_alive || move_done) begin
          adv = 1'b1;
        end else if (sec_tick) begin
          pres_d = '0;
          if (timer_q == LOG2_MAX_STEP_TIME'(1)) adv = 1'b1;
          else timer_d = timer_q - LOG2_MAX_STEP_TIME'(1);
        end else begin
          pres_d = pres_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (adv) begin
      cur_d   = next_player;
      timer_d = LOG2_MAX_STEP_TIME'(MAX_STEP_TIME);
      pres_d  = '0;
      ts_d    = 1'b1;
      if (next_player <= cur_q && !(&round_q)) round_d = round_q + LOG2_MAX_ROUND'(1);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      timer_q <= '0;
      round_q <= '0;
      ts_q    <= 1'b0;
      win_q   <= '0;
      pres_q  <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      timer_q <= timer_d;
      round_q <= round_d;
      ts_q    <= ts_d;
      win_q   <= win_d;
      pres_q  <= pres_d;
      start_q <= start;
    end
  end

  assign state          = state_q;
  assign current_player = cur_q;
  assign step_timer     = timer_q;
  assign round          = round_q;
  assign turn_start     = ts_q;
  assign game_over      = (state_q == OVER);
  assign winner         = win_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed plus random bench for turn_scheduler with a rule-level reference model.
module tb_turn_scheduler;
  localparam int NP = 7;
  localparam int MS = 15;
  localparam int T  = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       move_done = 1'b0;
  logic [2:0] first_player = 3'd0;
  logic [6:0] alive_mask = 7'b0000111;
  logic [1:0] state;
  logic [2:0] current_player, next_player, winner;
  logic [3:0] step_timer;
  logic [11:0] round;
  logic       turn_start, game_over;

  turn_scheduler #(.TICKS_PER_SEC(T)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .first_player(first_player),
    .alive_mask(alive_mask), .move_done(move_done), .state(state),
    .current_player(current_player), .next_player(next_player), .step_timer(step_timer),
    .round(round), .turn_start(turn_start), .game_over(game_over), .winner(winner)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int m_state, m_cur, m_timer, m_round, m_pres, m_ts, m_win;
  bit m_sq;

  function automatic bit alive(input int p, input logic [6:0] m);
    if (p < 1 || p > NP) return 1'b0;
    return ((int'(m) >> (p - 1)) & 1) == 1;
  endfunction

  // next alive player walking round the table after p
  function automatic int nxt(input int p, input logic [6:0] m);
    for (int k = 1; k <= NP; k++) begin
      int q;
      q = ((p + k - 1) % NP) + 1;
      if (alive(q, m)) return q;
    end
    return 0;
  endfunction

  function automatic int lone(input logic [6:0] m);
    if ($countones(m) != 1) return 0;
    for (int p = 1; p <= NP; p++) if (alive(p, m)) return p;
    return 0;
  endfunction

  task automatic mreset();
    m_state = 0; m_cur = 0; m_timer = 0; m_round = 0;
    m_pres = 0; m_ts = 0; m_win = 0; m_sq = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state", 32'(state), 32'(m_state));
    chk("current", 32'(current_player), 32'(m_cur));
    chk("next", 32'(next_player), 32'(nxt(m_cur, alive_mask)));
    chk("timer", 32'(step_timer), 32'(m_timer));
    chk("round", 32'(round), 32'(m_round));
    chk("turn_start", 32'(turn_start), 32'(m_ts));
    chk("game_over", 32'(game_over), 32'(m_state == 2));
    chk("winner", 32'(winner), 32'(m_win));
  endtask

  // apply the scheduler's rules to the inputs present before the coming edge
  task automatic model_step();
    int  pop;
    bit  rise, adv;
    pop  = $countones(alive_mask);
    rise = start && !m_sq;
    m_sq = start;
    m_ts = 0;
    adv  = 0;
    if (m_state != 1) begin
      if (rise) begin
        if (pop <= 1) begin
          m_state = 2; m_win = lone(alive_mask);
        end else begin
          m_state = 1; m_round = 1; m_timer = MS; m_ts = 1; m_pres = 0; m_win = 0;
          if (alive(int'(first_player), alive_mask)) m_cur = int'(first_player);
          else m_cur = nxt(int'(first_player), alive_mask);
        end
      end
    end else if (pop <= 1) begin
      m_state = 2; m_win = lone(alive_mask);
    end else if (!alive(m_cur, alive_mask) || move_done) begin
      adv = 1;
    end else if (m_pres == T - 1) begin
      m_pres = 0;
      if (m_timer == 1) adv = 1;
      else m_timer--;
    end else begin
      m_pres++;
    end
    if (adv) begin
      int n;
      n = nxt(m_cur, alive_mask);
      if (n <= m_cur && m_round < 4095) m_round++;
      m_cur = n; m_timer = MS; m_pres = 0; m_ts = 1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    check_all();
  endtask

  initial begin
    mreset();
    #2;
    check_all();
    chk("rst_state", 32'(state), 0);
    #6 reset_n = 1'b1;
    tick();

    // start edge with player 2 first
    first_player = 3'd2; start = 1'b1;
    tick();
    chk("t1_state", 32'(state), 1);
    chk("t1_cur", 32'(current_player), 2);
    chk("t1_next", 32'(next_player), 3);
    chk("t1_round", 32'(round), 1);
    chk("t1_timer", 32'(step_timer), 15);
    chk("t1_ts", 32'(turn_start), 1);
    tick();
    chk("t1_ts_pulse", 32'(turn_start), 0);

    // two moves: 2->3, then wrap 3->1 bumps the round
    move_done = 1'b1; tick(); move_done = 1'b0;
    chk("t2_cur3", 32'(current_player), 3);
    chk("t2_ts", 32'(turn_start), 1);
    move_done = 1'b1; tick(); move_done = 1'b0;
    chk("t2_cur1", 32'(current_player), 1);
    chk("t2_round2", 32'(round), 2);
    chk("t2_timer", 32'(step_timer), 15);

    // idle turn times out after 15 seconds of 4 cycles
    for (int i = 0; i < 59; i++) tick();
    chk("t3_timer1", 32'(step_timer), 1);
    chk("t3_cur_hold", 32'(current_player), 1);
    tick();
    chk("t3_timeout_cur", 32'(current_player), 2);
    chk("t3_timeout_timer", 32'(step_timer), 15);
    chk("t3_timeout_ts", 32'(turn_start), 1);

    // move on the same cycle as a second tick
    for (int i = 0; i < 3; i++) tick();
    move_done = 1'b1; tick(); move_done = 1'b0;
    chk("t4_cur", 32'(current_player), 3);
    chk("t4_timer", 32'(step_timer), 15);
    tick();
    chk("t4_timer_hold", 32'(step_timer), 15);

    // current player dies: forced advance to the next living one
    alive_mask = 7'b0010010; tick();
    chk("t5a_forced", 32'(current_player), 5);

    // asynchronous reset between edges
    #2 reset_n = 1'b0; start = 1'b0;
    mreset();
    #1;
    check_all();
    chk("t6_rst_cur", 32'(current_player), 0);
    chk("t6_rst_round", 32'(round), 0);
    #2 reset_n = 1'b1;
    move_done = 1'b1; tick(); move_done = 1'b0;
    chk("t6_idle_ignore", 32'(state), 0);

    // first player 5 alive, then lone survivor 2 wins
    first_player = 3'd5; start = 1'b1; tick();
    chk("t5_cur5", 32'(current_player), 5);
    start = 1'b0; tick();
    alive_mask = 7'b0000010; tick();
    chk("t5_over", 32'(state), 2);
    chk("t5_winner", 32'(winner), 2);
    chk("t5_game_over", 32'(game_over), 1);
    tick();
    alive_mask = 7'b0000011; first_player = 3'd0; start = 1'b1; tick();
    chk("t5_restart", 32'(state), 1);
    chk("t5_round1", 32'(round), 1);
    chk("t5_cur_scan", 32'(current_player), 1);

    // restart with only one player alive goes straight to OVER
    start = 1'b0; alive_mask = 7'b1000000; tick();
    tick();
    start = 1'b1; tick();
    chk("over_at_start", 32'(state), 2);
    chk("over_winner", 32'(winner), 7);

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      move_done = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) start = ~start;
      first_player = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 24) == 0) alive_mask = 7'($urandom_range(0, 127));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
